wide_add_seq: RTL

Word-serial wide adder sequencer. It accepts WORDS-word operand pairs as a valid/ready stream, least significant word first, and adds one WIDTH-bit word per cycle through a single PPA_Sklansky_19bit instance. The carry is chained between words in a register. A registered sum-word stream leaves the block, with the final carry-out attached to the last word. It sits directly upstream of the adder: it feeds it operands and carry-in, and registers what the adder produces, so the combinational adder can serve operands wider than 19 bits.

---
 rtl/wide_add_seq_pkg.sv | 20 ++
 rtl/wide_add_seq_adder.sv | 51 +++++
 rtl/wide_add_seq.sv | 102 ++++++++++
 3 files changed

// File: rtl/wide_add_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wide_add_seq_pkg                                       |
// | Description : Shared constants and helpers for the word-serial wide  |
// |               adder sequencer.                                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package wide_add_seq_pkg;

  // Word width of the combinational adder the sequencer drives.
  localparam int c_default_width = 19;

  // Word-index counter width; never narrower than one bit so WORDS=1 still
  // has a legal counter.
  function automatic int idx_width(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wide_add_seq_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : PPA_Sklansky_19bit                                     |
// | Description : Combinational Sklansky parallel-prefix adder with      |
// |               carry-in and carry-out.                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module PPA_Sklansky_19bit #(
  parameter int width = 19
) (
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic             cin,
  output logic [width-1:0] S,
  output logic             cout
);

  localparam int c_levels = (width <= 1) ? 1 : $clog2(width);

  logic [width-1:0] w_p;   // bitwise propagate, used for the sum
  logic [width-1:0] w_g;   // prefix generate: carry out of each bit
  logic [width-1:0] w_pp;  // prefix propagate
  logic [width-1:0] w_c;   // carry into each bit

  // Sklansky prefix tree; cin is folded into bit 0's generate so the tree
  // output is directly the carry out of each bit position.
  always_comb begin
    int j;
    j    = 0;
    w_p  = A ^ B;
    w_g  = A & B;
    w_g[0] = w_g[0] | (w_p[0] & cin);
    w_pp = w_p;
    for (int l = 0; l < c_levels; l++) begin
      for (int i = 0; i < width; i++) begin
        if (((i >> l) & 1) == 1) begin
          // j has bit l clear, so it is not updated at this level.
          j = ((i >> l) << l) - 1;
          w_g[i]  = w_g[i] | (w_pp[i] & w_g[j]);
          w_pp[i] = w_pp[i] & w_pp[j];
        end
      end
    end
  end

  assign w_c  = {w_g[width-2:0], cin};
  assign S    = w_p ^ w_c;
  assign cout = w_g[width-1];

endmodule
`default_nettype wire

// File: rtl/wide_add_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wide_add_seq                                           |
// | Description : Word-serial wide adder sequencer. Streams WORDS-word   |
// |               operands LS word first through one 19-bit adder,       |
// |               chaining the carry between words in a register.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter int WIDTH = c_default_width,
  parameter int WORDS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_last,
  output logic             out_cout,
  output logic             busy
);

  localparam int                 c_idx_w    = idx_width(WORDS);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(WORDS - 1);

  logic [c_idx_w-1:0] r_idx;
  logic               r_carry;
  logic [WIDTH-1:0]   r_out_s;
  logic               r_out_last;
  logic               r_out_cout;
  logic               r_out_valid;

  logic               w_fire_in;
  logic               w_is_first;
  logic               w_is_last;
  logic               w_add_cin;
  logic [WIDTH-1:0]   w_sum;
  logic               w_add_cout;

  // Single output stage: a new word may enter only if the stage is empty
  // or is being drained this cycle.
  assign in_ready   = ~r_out_valid | out_ready;
  assign w_fire_in  = in_valid & in_ready;

  // Operand framing comes solely from the word counter.
  assign w_is_first = (r_idx == '0);
  assign w_is_last  = (r_idx == c_last_idx);
  assign w_add_cin  = w_is_first ? in_cin : r_carry;

  PPA_Sklansky_19bit #(
    .width(WIDTH)
  ) u_adder (
    .A   (in_a),
    .B   (in_b),
    .cin (w_add_cin),
    .S   (w_sum),
    .cout(w_add_cout)
  );

  // Word counter and inter-word carry chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
    end else if (w_fire_in) begin
      r_carry <= w_add_cout;
      r_idx   <= w_is_last ? '0 : r_idx + 1'b1;
    end
  end

  // Output register: load on accept, clear valid on drain, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_s     <= '0;
      r_out_last  <= 1'b0;
      r_out_cout  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_fire_in) begin
      r_out_s     <= w_sum;
      r_out_last  <= w_is_last;
      r_out_cout  <= w_is_last & w_add_cout;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_s     = r_out_s;
  assign out_last  = r_out_last;
  assign out_cout  = r_out_cout;
  assign out_valid = r_out_valid;
  assign busy      = (r_idx != '0);

endmodule
`default_nettype wire
